// File: rtl/dpram_arb_pkg.sv
// Shared constants and helpers for the dual-port RAM arbiter.
// Lane numbering and slice math live here so the top and any client agree on them.
package dpram_arb_pkg;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    // One extra address bit so out-of-range requests are representable.
    function automatic int addr_w(input int height);
        return $clog2(height) + 1;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Round-robin first-one finder: first set, unmasked bit at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vector_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] index_o,
    output logic          found_o
);

    logic [N-1:0] cand;
    assign cand = vector_i & ~mask_i;

    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        found_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            automatic int j = (int'(ptr_i) + k) % N;
            if (!found_o && cand[j]) begin
                found_o     = 1'b1;
                index_o     = IW'(j);
                onehot_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Grants up to two requesters per cycle onto the two RAM ports with round-robin
// fairness, and returns registered read data one cycle after the grant.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int HEIGHT  = 48,
    parameter int ADDR_W  = addr_w(HEIGHT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [NUM_REQ-1:0]        rerr,
    output logic [2*WIDTH-1:0]        rdata,
    output logic [NUM_REQ-1:0]        rport,
    output logic [ADDR_W-1:0]         ram_addr_a,
    output logic [ADDR_W-1:0]         ram_addr_b,
    output logic [WIDTH-1:0]          ram_data_a,
    output logic [WIDTH-1:0]          ram_data_b,
    output logic                      ram_we_a,
    output logic                      ram_we_b,
    input  logic [WIDTH-1:0]          ram_q_a,
    input  logic [WIDTH-1:0]          ram_q_b
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
    logic [NUM_REQ-1:0]   rerr_q, rerr_d;
    logic [NUM_REQ-1:0]   rport_q, rport_d;
    logic [2*WIDTH-1:0]   rdata_q, rdata_d;

    logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
    logic [WIDTH-1:0]     wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*WIDTH +: WIDTH];
    end

    logic [NUM_REQ-1:0] oh_a, oh_b;
    logic [IW-1:0]      idx_a, idx_b;
    logic               found_a, found_b;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_a (
        .vector_i (req),
        .ptr_i    (rr_ptr_q),
        .mask_i   ('0),
        .onehot_o (oh_a),
        .index_o  (idx_a),
        .found_o  (found_a)
    );

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_b (
        .vector_i (req),
        .ptr_i    (rr_ptr_q),
        .mask_i   (oh_a),
        .onehot_o (oh_b),
        .index_o  (idx_b),
        .found_o  (found_b)
    );

    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [WIDTH-1:0]  wdata_a, wdata_b;
    logic              we_a, we_b, inr_a, inr_b, conflict, gnt_a, gnt_b;

    assign addr_a  = addr_arr[idx_a];
    assign addr_b  = addr_arr[idx_b];
    assign wdata_a = wdata_arr[idx_a];
    assign wdata_b = wdata_arr[idx_b];
    assign we_a    = req_we[idx_a];
    assign we_b    = req_we[idx_b];
    assign inr_a   = addr_a < ADDR_W'(HEIGHT);
    assign inr_b   = addr_b < ADDR_W'(HEIGHT);

    // Two writes to one address: port B backs off rather than racing port A.
    assign conflict = found_a && found_b && we_a && we_b && (addr_a == addr_b);
    assign gnt_a    = rst_n && found_a;
    assign gnt_b    = rst_n && found_b && !conflict;

    assign gnt = (gnt_a ? oh_a : '0) | (gnt_b ? oh_b : '0);

    assign ram_we_a   = gnt_a && we_a && inr_a;
    assign ram_we_b   = gnt_b && we_b && inr_b;
    assign ram_addr_a = gnt_a ? addr_a : '0;
    assign ram_addr_b = gnt_b ? addr_b : '0;
    assign ram_data_a = gnt_a ? wdata_a : '0;
    assign ram_data_b = gnt_b ? wdata_b : '0;

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        rvalid_d = '0;
        rerr_d   = '0;
        rport_d  = '0;
        rdata_d  = rdata_q;

        if (gnt_b)
            rr_ptr_d = ptr_after(idx_b);
        else if (gnt_a)
            rr_ptr_d = ptr_after(idx_a);

        if (gnt_a) begin
            if (!inr_a) begin
                rerr_d[idx_a] = 1'b1;
            end else if (!we_a) begin
                rvalid_d[idx_a] = 1'b1;
                rport_d[idx_a]  = 1'(PORT_A);
                rdata_d[lane_lo(PORT_A, WIDTH) +: WIDTH] = ram_q_a;
            end
        end
        if (gnt_b) begin
            if (!inr_b) begin
                rerr_d[idx_b] = 1'b1;
            end else if (!we_b) begin
                rvalid_d[idx_b] = 1'b1;
                rport_d[idx_b]  = 1'(PORT_B);
                rdata_d[lane_lo(PORT_B, WIDTH) +: WIDTH] = ram_q_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            rvalid_q <= '0;
            rerr_q   <= '0;
            rport_q  <= '0;
            rdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rport_q  <= rport_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rerr   = rerr_q;
    assign rport  = rport_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: behavioural RAM, shadow memory and a return scoreboard.
module tb_dpram_port_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int H  = 48;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    req, req_we, gnt, rvalid, rerr, rport;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_wdata;
    logic [2*W-1:0]  rdata;
    logic [AW-1:0]   ram_addr_a, ram_addr_b;
    logic [W-1:0]    ram_data_a, ram_data_b, ram_q_a, ram_q_b;
    logic            ram_we_a, ram_we_b;

    dpram_port_arbiter #(.NUM_REQ(N), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
        .rvalid(rvalid), .rerr(rerr), .rdata(rdata), .rport(rport),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
    );

    // Behavioural RAM: registered write, combinational read.
    logic [W-1:0] mem [H];
    logic [W-1:0] shadow [H];
    logic         mem_init;

    assign ram_q_a = (ram_addr_a < AW'(H)) ? mem[ram_addr_a[5:0]] : '0;
    assign ram_q_b = (ram_addr_b < AW'(H)) ? mem[ram_addr_b[5:0]] : '0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < H; k++) mem[k] <= k * 32'h0101_0101;
        end else begin
            if (ram_we_a) mem[ram_addr_a[5:0]] <= ram_data_a;
            if (ram_we_b) mem[ram_addr_b[5:0]] <= ram_data_b;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    typedef struct {
        int         idx;
        logic [W-1:0] data;
        logic       err;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // Return monitor: every rvalid/rerr pulse must match the next expected entry.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (rvalid[i] || rerr[i]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_return", 64'(i), 64'hFF);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("ret_idx", 64'(i), 64'(mon_e.idx));
                    chk("ret_err", {63'd0, rerr[i]}, {63'd0, mon_e.err});
                    if (!mon_e.err)
                        chk("ret_data", rport[i] ? rdata[W +: W] : rdata[0 +: W], mon_e.data);
                end
            end
        end
    end

    logic [N-1:0][AW-1:0] A;
    logic [N-1:0][W-1:0]  D;

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] we,
                       input logic [N-1:0][AW-1:0] a, input logic [N-1:0][W-1:0] d,
                       input logic [N-1:0] eg, input string tag);
        exp_t e;
        @(negedge clk);
        req = r; req_we = we; req_addr = a; req_wdata = d;
        #1 chk(tag, 64'(gnt), 64'(eg));
        for (int i = 0; i < N; i++) begin
            if (eg[i]) begin
                e.idx = i;
                e.err = (a[i] >= AW'(H));
                e.data = e.err ? '0 : shadow[a[i][5:0]];
                if (e.err || !we[i]) sbq.push_back(e);
            end
        end
        for (int i = 0; i < N; i++)
            if (eg[i] && we[i] && a[i] < AW'(H)) shadow[a[i][5:0]] = d[i];
        @(posedge clk);
    endtask

    initial begin
        exp_t e;
        mem_init = 1'b0;
        for (int k = 0; k < H; k++) shadow[k] = k * 32'h0101_0101;
        rst_n = 1'b0;
        req = '1; req_we = '0; req_wdata = '0;
        for (int i = 0; i < N; i++) A[i] = AW'(10 + i);
        D = '0;
        req_addr = A;
        repeat (3) @(posedge clk);
        mem_init = 1'b1;
        @(negedge clk); #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_we", {62'd0, ram_we_a, ram_we_b}, 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Release and fairness: all four read continuously.
        cyc(4'hF, 4'h0, A, D, 4'b0011, "rel_first");
        cyc(4'hF, 4'h0, A, D, 4'b1100, "fair_1");
        cyc(4'hF, 4'h0, A, D, 4'b0011, "fair_2");
        cyc(4'hF, 4'h0, A, D, 4'b1100, "fair_3");
        cyc(4'h0, 4'h0, A, D, 4'b0000, "idle");

        // Write then read back through another requester.
        A = '0; D = '0; A[0] = 7'd5; D[0] = 32'hDEAD_BEEF;
        cyc(4'b0001, 4'b0001, A, D, 4'b0001, "wr5");
        A[2] = 7'd5;
        cyc(4'b0100, 4'b0000, A, D, 4'b0100, "rd5");

        // Same-address writes with rr_ptr at 1.
        A = '0;
        cyc(4'b0001, 4'b0000, A, D, 4'b0001, "ptr_to_1");
        A[1] = 7'd7; A[3] = 7'd7; D[1] = 32'h1111_0001; D[3] = 32'h3333_0003;
        cyc(4'b1010, 4'b1010, A, D, 4'b0010, "ww_conflict");
        cyc(4'b1000, 4'b1000, A, D, 4'b1000, "ww_second");
        A[0] = 7'd7;
        cyc(4'b0001, 4'b0000, A, D, 4'b0001, "rd7");
        chk("mem7", mem[7], 32'h3333_0003);

        // Read/write collision on one address.
        A = '0; D = '0; A[0] = 7'd9; D[0] = 32'h11;
        cyc(4'b0001, 4'b0001, A, D, 4'b0001, "wr9_init");
        A[1] = 7'd9; D[0] = 32'h22;
        cyc(4'b0011, 4'b0001, A, D, 4'b0011, "rw_collide");
        A[2] = 7'd9;
        cyc(4'b0100, 4'b0000, A, D, 4'b0100, "rd9_after");
        chk("mem9", mem[9], 32'h22);

        // Out of range read and write.
        A = '0; A[2] = 7'd48;
        cyc(4'b0100, 4'b0000, A, D, 4'b0100, "oor_read");
        A[1] = 7'd50; D[1] = 32'hBAD0_BAD0;
        @(negedge clk);
        req = 4'b0010; req_we = 4'b0010; req_addr = A; req_wdata = D;
        #1;
        chk("oor_wr_gnt", 64'(gnt), 64'h2);
        chk("oor_wr_we", {62'd0, ram_we_a, ram_we_b}, 64'h0);
        e.idx = 1; e.err = 1'b1; e.data = '0;
        sbq.push_back(e);
        @(posedge clk);

        // Reset lands before the grant edge of a read: no return may appear.
        A = '0; A[3] = 7'd3;
        @(negedge clk);
        req = 4'b1000; req_we = '0; req_addr = A;
        #1 chk("pre_rst_gnt", 64'(gnt), 64'h8);
        #1 rst_n = 1'b0;
        #1 chk("in_rst_gnt", 64'(gnt), 64'h0);
        @(posedge clk); #3;
        chk("rst_drop_rvalid", 64'(rvalid), 64'h0);
        chk("rst_drop_we", {62'd0, ram_we_a, ram_we_b}, 64'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < N; i++) A[i] = AW'(10 + i);
        cyc(4'hF, 4'h0, A, D, 4'b0011, "ptr_after_rst");
        cyc(4'h0, 4'h0, A, D, 4'b0000, "idle_end");
        repeat (2) @(posedge clk);
        #4 chk("sb_empty", 64'(sbq.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
